// File: rtl/ext_fifo_tx_pktbuf.sv
// Store-and-forward TX frame buffer: a frame is presented downstream only after its last
// byte is stored cleanly, so the MAC-side stream never stalls mid-frame.
module ext_fifo_tx_pktbuf #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [ADDR_W-1:0] pkt_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic              drop_o,
    output logic [ADDR_W:0]   free_o
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [ADDR_W:0] Cap = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StFill, StDiscard} wr_state_e;

    logic [8:0]        mem [Depth];
    wr_state_e         state;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   cm_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              ready;
    logic [8:0]        out_word;
    logic              out_valid;
    logic [ADDR_W-1:0] pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              drop_pulse;

    logic              accept;
    logic              full;
    logic              wr_en;
    logic              commit;
    logic              drop_ev;
    logic              fetch;
    logic              pop_last;

    assign s_axis_tready = ready & rstn;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign full          = (wr_ptr - rd_ptr) == Cap;

    // Write decision: a beat that cannot be stored poisons the rest of its frame.
    always_comb begin
        wr_en   = 1'b0;
        commit  = 1'b0;
        drop_ev = 1'b0;
        if (accept) begin
            unique case (state)
                StIdle, StFill: begin
                    if (s_axis_tlast && s_axis_tuser) begin
                        drop_ev = 1'b1;
                    end else if (full) begin
                        drop_ev = s_axis_tlast;
                    end else begin
                        wr_en  = 1'b1;
                        commit = s_axis_tlast;
                    end
                end
                StDiscard: drop_ev = s_axis_tlast;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= StIdle;
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            ready      <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            ready      <= 1'b1;
            drop_pulse <= drop_ev;
            if (drop_ev && drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (accept) begin
                unique case (state)
                    StIdle, StFill: begin
                        if (drop_ev || commit) begin
                            state <= StIdle;
                        end else if (wr_en) begin
                            state <= StFill;
                        end else begin
                            state <= StDiscard;
                        end
                    end
                    StDiscard: begin
                        if (s_axis_tlast) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
            // A dropped frame rewinds to the last commit point, freeing its bytes.
            if (drop_ev) begin
                wr_ptr <= cm_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                cm_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // The RAM read register doubles as the output register; it only advances on a fetch,
    // which keeps data stable under backpressure.
    assign fetch    = (rd_ptr != cm_ptr) && (!out_valid || m_axis_tready);
    assign pop_last = out_valid & m_axis_tready & out_word[8];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr    <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
        end else if (fetch) begin
            out_word  <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr    <= rd_ptr + 1'b1;
            out_valid <= 1'b1;
        end else if (m_axis_tready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt <= '0;
        end else if (commit && !pop_last) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end else if (pop_last && !commit) begin
            pkt_cnt <= pkt_cnt - 1'b1;
        end
    end

    assign m_axis_tdata  = out_word[7:0];
    assign m_axis_tlast  = out_word[8];
    assign m_axis_tvalid = out_valid;
    assign pkt_cnt_o     = pkt_cnt;
    assign drop_cnt_o    = drop_cnt;
    assign drop_o        = drop_pulse;
    assign free_o        = Cap - (cm_ptr - rd_ptr);

endmodule

// File: doc/ext_fifo_tx_pktbuf.md
Name: ext_fifo_tx_pktbuf

Overview:
Store-and-forward TX frame buffer placed directly upstream of the GEM external-FIFO TX adapter. It accepts byte-wide AXI4-Stream frames from the DMA/packet source and writes them into a local RAM. A frame is released to the downstream AXI4-Stream only after its last byte is stored without error. This guarantees the MAC never sees a mid-frame stall, so TX underflow cannot occur. Errored or oversize frames are dropped in full and counted.

Parameters:
ADDR_W, 11, RAM address width; depth = 2^ADDR_W bytes, usable capacity = 2^ADDR_W - 1 bytes.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
s_axis_tdata  input  8  frame byte in
s_axis_tvalid  input  1  input byte valid
s_axis_tready  output  1  input ready
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  1  frame error flag, sampled on the tlast beat
m_axis_tdata  output  8  frame byte out, toward the TX adapter
m_axis_tvalid  output  1  output byte valid
m_axis_tready  input  1  output ready (TX adapter rd strobe)
m_axis_tlast  output  1  last byte of frame
pkt_cnt_o  output  ADDR_W  committed frames not yet fully read out
drop_cnt_o  output  CNT_W  dropped frames, saturating at all-ones
drop_o  output  1  one-cycle pulse per dropped frame
free_o  output  ADDR_W+1  free bytes, computed from committed write pointer and read pointer

Behaviour:
- Reset is synchronous, rstn=0 on a rising edge. All pointers, counters and flags clear.
  - Outputs next cycle: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pkt_cnt_o=0, drop_cnt_o=0, drop_o=0, free_o=2^ADDR_W-1.
  - s_axis_tready=0 while rstn=0, and 1 from the first cycle after reset is released.
  - Reset mid-frame discards all stored and partial frames. No output beat completes after reset.
- Storage: 2^ADDR_W x 9-bit RAM holding {tlast, tdata}, synchronous read, one write port and one read port.
- Pointers, each ADDR_W+1 bits with a wrap bit:
  - wr_ptr: working write pointer.
  - cm_ptr: committed write pointer.
  - rd_ptr: read pointer.
  - Full: wr_ptr - rd_ptr == 2^ADDR_W - 1 (modulo arithmetic).
  - Empty (readable): rd_ptr == cm_ptr.
- Write FSM states: IDLE, FILL, DISCARD.
  - IDLE, on accepted beat: write the byte, wr_ptr++, go to FILL. If that beat also has tlast, apply the tlast rule in the same cycle.
  - FILL, on accepted beat:
    - Not full: write, wr_ptr++.
    - Full: do not write, go to DISCARD.
  - Tlast beat, no error, not discarded: write, then cm_ptr <= wr_ptr+1, pkt_cnt++, go to IDLE.
  - Tlast beat with tuser=1 (or tlast received in DISCARD): wr_ptr <= cm_ptr, drop_o=1 for one cycle, drop_cnt++ (saturating), go to IDLE.
  - s_axis_tready stays 1 in every state except reset. A full buffer causes a frame drop, never backpressure.
  - Consequence: any frame longer than 2^ADDR_W-1 bytes is always dropped.
- Read side:
  - Fetch from RAM[rd_ptr] when rd_ptr != cm_ptr and the output register is empty or being consumed this cycle.
  - The output register loads one cycle after the fetch.
  - m_axis_tvalid first rises 2 cycles after the committing tlast handshake.
  - Sustained throughput is 1 byte/cycle while m_axis_tready=1.
  - Output data and tlast hold stable while tvalid=1 and tready=0.
- pkt_cnt_o:
  - +1 on commit, -1 on an m_axis handshake with tlast=1.
  - Both events in the same cycle leave it unchanged.
- free_o updates on commit and on each read fetch. Bytes of an in-progress frame are not subtracted.
- Frames never interleave: output frame order equals commit order.

Test Plan:
- Single 64-byte frame 0x00..0x3F, tuser=0, m_axis_tready=1 -> m_axis_tvalid rises 2 cycles after the input tlast. 64 contiguous beats 0x00..0x3F, tlast only on 0x3F. pkt_cnt_o goes 1 then 0. free_o returns to 2047.
- Frame of 10 bytes with tuser=1 on tlast, followed by a good 5-byte frame -> drop_o pulses once, drop_cnt_o=1. Only the 5-byte frame appears on the output. free_o is unaffected by the dropped frame.
- m_axis_tready=0, write 3 frames of 600 bytes; the third overflows (1800 > 2047 is false, so use 4 frames of 600) -> frames 1-3 commit (pkt_cnt_o=3), frame 4 enters DISCARD, drop_cnt_o=1. s_axis_tready stays high throughout. Release tready -> exactly 1800 bytes out, 3 tlast beats.
- Oversize 2100-byte frame into an empty buffer -> dropped, drop_cnt_o=1, m_axis_tvalid never asserts, free_o=2047.
- Random m_axis_tready (50%) during concurrent write/read of 20 random-length frames (1-300 bytes) -> output byte stream and tlast positions match the committed input exactly. Hold-stability holds on every stalled cycle. pkt_cnt_o is never negative.
- Assert rstn=0 for 1 cycle mid-readout of a 100-byte frame -> next cycle m_axis_tvalid=0, pkt_cnt_o=0, drop_cnt_o=0. A fresh 4-byte frame afterwards is delivered correctly.
